verprefetch: RTL and testbench
==============================

Name: verprefetch

Overview:
Instruction prefetch buffer between the core's instruction fetch bus and instruction memory. It fetches sequential words ahead of the core into a small FIFO. Hits are served in zero cycles. On a PC discontinuity (jump, trap) it flushes and refetches from the requested address. It follows the core bus handshake: valid is held with a stable address until ready, and ready is pulsed for one cycle with rdata.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
RESET_ADDR, 0, first prefetch address after reset; word aligned.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
core_valid  in  1  core requests the instruction at core_address.
core_ready  out  1  core_rdata valid this cycle; the request completes.
core_address  in  32  byte address; bits [1:0] ignored.
core_rdata  out  32  instruction word.
flush  in  1  one-cycle pulse (fence.i) that discards all buffered words.
mem_valid  out  1  memory request.
mem_ready  in  1  memory response valid.
mem_address  out  32  word-aligned request address; [1:0] = 0.
mem_rdata  in  32  response data.

Behaviour:
- Registered state: FIFO storage, rd_ptr, wr_ptr, count (0..DEPTH), head_addr (address of the oldest entry), fetch_addr, and state in {IDLE, FETCH, DRAIN}.
- Reset values: count=0, pointers=0, head_addr=fetch_addr=RESET_ADDR, state=FETCH. Outputs: mem_valid=1 (first request issued straight out of reset), mem_address=RESET_ADDR, core_ready=0, core_rdata=0.
- Address compare uses bits [31:2] only. Address increment is +4 modulo 2^32, so 0xFFFFFFFC wraps to 0.
- Invariant: in FETCH, fetch_addr = head_addr + 4*count.
- mem_valid = (state != IDLE); mem_address = fetch_addr. Both are stable while mem_valid=1 and mem_ready=0.
- Hit: core_valid, count>0, core_address==head_addr.
  - core_ready=1 combinationally; core_rdata = FIFO[rd_ptr].
  - Pop: head_addr+=4, count-=1.
- Bypass: core_valid, state==FETCH, count==0, mem_ready, core_address==fetch_addr.
  - core_ready=1 and core_rdata=mem_rdata in the same cycle; the word is not stored.
  - head_addr = fetch_addr+4.
- Wait: core_valid, count==0, core_address==head_addr, no mem_ready. No action; core_ready=0.
- Miss: core_valid and none of hit, bypass or wait.
  - count:=0 and head_addr:=core_address.
  - If state==FETCH and mem_ready: response discarded, next state FETCH with fetch_addr:=core_address.
  - If state==FETCH and no mem_ready: next state DRAIN (the outstanding request cannot be cancelled).
  - If state==DRAIN: stay in DRAIN; head_addr is updated.
  - If state==IDLE: next state FETCH with fetch_addr:=core_address.
- Miss latency from the miss cycle: 1 cycle plus memory latency, plus the remaining drain time of any outstanding request.
- FETCH on mem_ready, no bypass, no miss:
  - Push mem_rdata at wr_ptr; count+=1; fetch_addr+=4.
  - Stay in FETCH if the post-update count < DEPTH, else go to IDLE.
  - Back-to-back requests keep mem_valid high and update the address on the same edge.
- Simultaneous hit-pop and push: count unchanged; both pointers advance.
- Full: count==DEPTH puts the block in IDLE; no request is issued.
- IDLE→FETCH on the edge after count drops below DEPTH, with fetch_addr = head_addr + 4*count_next.
- DRAIN on mem_ready: data discarded; next state FETCH with fetch_addr:=head_addr.
- flush: count:=0 and head_addr unchanged. A request outstanding in FETCH goes to DRAIN. flush has priority over a same-cycle push; a hit in the same cycle is still served.
- Reset asserted mid-transfer: all state clears immediately; any late mem_ready from the aborted access is not tracked. The memory side must also be reset.
- Pointer arithmetic is log2(DEPTH) bits, wrapping naturally; count is log2(DEPTH)+1 bits.

Decomposition:
- Verdata_pkg: word_t.
- New Verprefetch_pkg: prefetch_state_t enum {IDLE, FETCH, DRAIN} and the WORD_INCR=4 constant.
- One natural sub-module, verprefetch_fifo: DEPTH-entry synchronous FIFO exposing push, pop, clear, count, head data. The prefetch control FSM stays in verprefetch.

Test Plan:
1. Release reset with memory at 1-cycle latency and the core requesting 0,4,8,… every cycle → mem_address 0,4,8,12 back-to-back. Core gets a bypass at 0, then zero-latency hits. Fills to 4 entries when the core stalls.
2. Fill FIFO (count=4) and hold core_valid=0 → mem_valid=0. One pop → mem_valid=1 next cycle with mem_address=head_addr+16.
3. Buffer holding 0x100..0x10C with a request to 0x110 outstanding, core requests 0x400 → DRAIN. Data for 0x110 is discarded. Next mem_address=0x400, and core_ready arrives with data from 0x400.
4. Miss to 0x400 in the same cycle as mem_ready for 0x110 → no DRAIN cycle; mem_address=0x400 on the next cycle.
5. Start at 0xFFFFFFF8 → prefetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; the core sequence wraps without a miss.
6. flush pulse with count=3 → count=0. Next request at head_addr refetches from memory; stale data is never returned.

Source files
------------

// File: rtl/verdata_pkg.sv
// Shared data types for the instruction-side datapath.
//   word_t : 32-bit instruction / address word.
package verdata_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/verprefetch_pkg.sv
// Types, constants and address helpers for the instruction prefetch buffer.
//   prefetch_state_t : control FSM states (IDLE, FETCH, DRAIN).
//   WORD_INCR        : byte stride between consecutive instruction words.
//   addr_match       : word-granular address compare (bits [1:0] ignored).
//   word_align       : clears the byte-offset bits of an address.
package verprefetch_pkg;
  import verdata_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } prefetch_state_t;

  localparam word_t WORD_INCR = 32'd4;

  function automatic logic addr_match(input word_t a, input word_t b);
    return a[31:2] == b[31:2];
  endfunction

  function automatic word_t word_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/verprefetch_fifo.sv
// DEPTH-entry synchronous FIFO holding prefetched instruction words.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   push, wr_data     : write wr_data at the tail
//   pop               : discard the head entry
//   clear             : empty the FIFO (wins over push/pop)
//   count             : number of valid entries, 0..DEPTH
//   head_data         : oldest entry (meaningful when count > 0)
// The controller never pops an empty FIFO or pushes a full one.
module verprefetch_fifo
  import verdata_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  word_t            wr_data,
  output logic [CNT_W-1:0] count,
  output word_t            head_data
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  word_t            mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/verprefetch.sv
// Instruction prefetch buffer between the core fetch port and instruction memory.
// Fetches sequential words ahead of the core into a FIFO; hits are answered in
// the same cycle, a PC discontinuity flushes and refetches from the new address.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   core_valid, core_address   : core fetch request (held until core_ready)
//   core_ready, core_rdata     : one-cycle completion with the instruction word
//   flush                      : one-cycle pulse discarding all buffered words
//   mem_valid, mem_address     : memory request, stable until mem_ready
//   mem_ready, mem_rdata       : memory response
//
// state | meaning
// IDLE  | FIFO full, no memory request outstanding
// FETCH | request for fetch_addr outstanding; response is pushed or bypassed
// DRAIN | stale request outstanding; its response is dropped, then refetch head
module verprefetch
  import verdata_pkg::*;
  import verprefetch_pkg::*;
#(
  parameter int    DEPTH      = 4,
  parameter word_t RESET_ADDR = '0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  core_valid,
  output logic  core_ready,
  input  word_t core_address,
  output word_t core_rdata,
  input  logic  flush,
  output logic  mem_valid,
  input  logic  mem_ready,
  output word_t mem_address,
  input  word_t mem_rdata
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam word_t            START_PC  = {RESET_ADDR[31:2], 2'b00};

  prefetch_state_t  state, state_next;
  word_t            head_addr, head_next;
  word_t            fetch_addr, fetch_next;
  word_t            core_word;
  word_t            head_data;
  logic [CNT_W-1:0] fifo_count, count_next;
  logic             hit, bypass, hold, miss;
  logic             push, pop, clear;
  logic             addr_lsb_unused;

  assign core_word       = word_align(core_address);
  assign addr_lsb_unused = ^core_address[1:0];

  assign hit    = core_valid && (fifo_count != '0) && addr_match(core_address, head_addr);
  assign bypass = core_valid && (state == FETCH) && (fifo_count == '0) && mem_ready &&
                  addr_match(core_address, fetch_addr);
  assign hold   = core_valid && (fifo_count == '0) && !mem_ready &&
                  addr_match(core_address, head_addr);
  assign miss   = core_valid && !hit && !bypass && !hold;

  assign pop   = hit;
  assign clear = miss || flush;

  assign core_ready  = hit || bypass;
  assign core_rdata  = hit ? head_data : (bypass ? mem_rdata : '0);
  assign mem_address = fetch_addr;

  always_comb begin
    state_next = state;
    head_next  = head_addr;
    fetch_next = fetch_addr;
    push       = 1'b0;

    if (hit)         head_next = head_addr + WORD_INCR;
    else if (bypass) head_next = fetch_addr + WORD_INCR;
    else if (miss)   head_next = core_word;

    case (state)
      FETCH: begin
        // A miss or flush restarts at the (new) head; an unanswered request
        // cannot be withdrawn, so its response must be drained first.
        if (miss || flush) begin
          if (mem_ready) fetch_next = head_next;
          else           state_next = DRAIN;
        end else if (mem_ready) begin
          fetch_next = fetch_addr + WORD_INCR;
          push       = !bypass;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          state_next = FETCH;
          fetch_next = head_next;
        end
      end
      IDLE:    state_next = IDLE;
      default: state_next = FETCH;
    endcase

    count_next = clear ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);

    // Resume prefetching right behind the last buffered word once room appears.
    if (state == IDLE && count_next != FULL) begin
      state_next = FETCH;
      fetch_next = head_next + (word_t'(count_next) << 2);
    end
    if (state == FETCH && push && count_next == FULL) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      mem_valid  <= 1'b1;
      head_addr  <= START_PC;
      fetch_addr <= START_PC;
    end else begin
      state      <= state_next;
      mem_valid  <= (state_next != IDLE);
      head_addr  <= head_next;
      fetch_addr <= fetch_next;
    end
  end

  verprefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .wr_data   (mem_rdata),
    .count     (fifo_count),
    .head_data (head_data)
  );

endmodule

// File: tb/tb_verprefetch.sv
// Directed bench for verprefetch (DEPTH=4, RESET_ADDR=0). Memory answers with
// the bitwise inverse of the requested address whenever mem_ready is driven.
module tb_verprefetch;

  typedef struct {
    logic        cv;
    logic [31:0] addr;
    logic        fl;
    logic        mr;
    logic        exp_cr;
    logic [31:0] exp_rd;
    logic        exp_mv;
    logic [31:0] exp_ma;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        core_valid;
  logic        core_ready;
  logic [31:0] core_address;
  logic [31:0] core_rdata;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl [18];

  verprefetch #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .core_valid   (core_valid),
    .core_ready   (core_ready),
    .core_address (core_address),
    .core_rdata   (core_rdata),
    .flush        (flush),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_ready ? ~mem_address : 32'h0;

  function automatic vec_t mk(input logic cv, input logic [31:0] addr, input logic fl,
                              input logic mr, input logic cr, input logic [31:0] rd,
                              input logic mv, input logic [31:0] ma);
    vec_t v;
    v.cv = cv; v.addr = addr; v.fl = fl; v.mr = mr;
    v.exp_cr = cr; v.exp_rd = rd; v.exp_mv = mv; v.exp_ma = ma;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    core_valid   = v.cv;
    core_address = v.addr;
    flush        = v.fl;
    mem_ready    = v.mr;
    #1;
    check($sformatf("%s.core_ready", tag), {31'b0, core_ready}, {31'b0, v.exp_cr});
    if (v.exp_cr) check($sformatf("%s.core_rdata", tag), core_rdata, v.exp_rd);
    check($sformatf("%s.mem_valid", tag), {31'b0, mem_valid}, {31'b0, v.exp_mv});
    check($sformatf("%s.mem_address", tag), mem_address, v.exp_ma);
  endtask

  task automatic do_reset(input string tag);
    reset        = 1'b0;
    core_valid   = 1'b0;
    core_address = 32'h0;
    flush        = 1'b0;
    mem_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check($sformatf("%s.rst_mem_valid", tag), {31'b0, mem_valid}, 32'h1);
    check($sformatf("%s.rst_mem_address", tag), mem_address, 32'h0);
    check($sformatf("%s.rst_core_ready", tag), {31'b0, core_ready}, 32'h0);
    check($sformatf("%s.rst_core_rdata", tag), core_rdata, 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end of the test");
    $fatal(1, "timeout");
  end

  initial begin
    // Sequential streaming, fill to full, restart after a pop, wait then bypass.
    tbl[0]  = mk(1, 32'h00, 0, 1,  1, ~32'h00, 1, 32'h00);
    tbl[1]  = mk(0, 32'h00, 0, 1,  0, 32'h0,   1, 32'h04);
    tbl[2]  = mk(0, 32'h00, 0, 1,  0, 32'h0,   1, 32'h08);
    tbl[3]  = mk(1, 32'h04, 0, 1,  1, ~32'h04, 1, 32'h0C);
    tbl[4]  = mk(1, 32'h08, 0, 0,  1, ~32'h08, 1, 32'h10);
    tbl[5]  = mk(0, 32'h00, 0, 1,  0, 32'h0,   1, 32'h10);
    tbl[6]  = mk(0, 32'h00, 0, 1,  0, 32'h0,   1, 32'h14);
    tbl[7]  = mk(0, 32'h00, 0, 1,  0, 32'h0,   1, 32'h18);
    tbl[8]  = mk(0, 32'h00, 0, 0,  0, 32'h0,   0, 32'h1C);
    tbl[9]  = mk(0, 32'h00, 0, 0,  0, 32'h0,   0, 32'h1C);
    tbl[10] = mk(1, 32'h0C, 0, 0,  1, ~32'h0C, 0, 32'h1C);
    tbl[11] = mk(0, 32'h00, 0, 0,  0, 32'h0,   1, 32'h1C);
    tbl[12] = mk(1, 32'h10, 0, 0,  1, ~32'h10, 1, 32'h1C);
    tbl[13] = mk(1, 32'h14, 0, 1,  1, ~32'h14, 1, 32'h1C);
    tbl[14] = mk(1, 32'h18, 0, 0,  1, ~32'h18, 1, 32'h20);
    tbl[15] = mk(1, 32'h1C, 0, 0,  1, ~32'h1C, 1, 32'h20);
    tbl[16] = mk(1, 32'h20, 0, 0,  0, 32'h0,   1, 32'h20);
    tbl[17] = mk(1, 32'h20, 0, 1,  1, ~32'h20, 1, 32'h20);

    do_reset("stream");
    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("stream[%0d]", i));

    // Miss while a request is outstanding: drain, then refetch the target.
    do_reset("drain");
    apply(mk(1, 32'h100, 0, 1, 0, 32'h0,    1, 32'h000), "drain.miss100");
    apply(mk(0, 32'h000, 0, 1, 0, 32'h0,    1, 32'h100), "drain.f100");
    apply(mk(0, 32'h000, 0, 1, 0, 32'h0,    1, 32'h104), "drain.f104");
    apply(mk(0, 32'h000, 0, 1, 0, 32'h0,    1, 32'h108), "drain.f108");
    apply(mk(0, 32'h000, 0, 1, 0, 32'h0,    1, 32'h10C), "drain.f10C");
    apply(mk(1, 32'h100, 0, 0, 1, ~32'h100, 0, 32'h110), "drain.hit100");
    apply(mk(1, 32'h400, 0, 0, 0, 32'h0,    1, 32'h110), "drain.miss400");
    apply(mk(1, 32'h400, 0, 0, 0, 32'h0,    1, 32'h110), "drain.hold");
    apply(mk(1, 32'h400, 0, 1, 0, 32'h0,    1, 32'h110), "drain.discard");
    apply(mk(1, 32'h400, 0, 1, 1, ~32'h400, 1, 32'h400), "drain.byp400");

    // Miss coinciding with the response: no drain cycle.
    do_reset("nodrain");
    apply(mk(1, 32'h100, 0, 1, 0, 32'h0,    1, 32'h000), "nodrain.miss100");
    apply(mk(0, 32'h000, 0, 1, 0, 32'h0,    1, 32'h100), "nodrain.f100");
    apply(mk(0, 32'h000, 0, 1, 0, 32'h0,    1, 32'h104), "nodrain.f104");
    apply(mk(0, 32'h000, 0, 1, 0, 32'h0,    1, 32'h108), "nodrain.f108");
    apply(mk(0, 32'h000, 0, 1, 0, 32'h0,    1, 32'h10C), "nodrain.f10C");
    apply(mk(1, 32'h100, 0, 0, 1, ~32'h100, 0, 32'h110), "nodrain.hit100");
    apply(mk(1, 32'h400, 0, 1, 0, 32'h0,    1, 32'h110), "nodrain.miss400");
    apply(mk(1, 32'h400, 0, 1, 1, ~32'h400, 1, 32'h400), "nodrain.byp400");

    // Address wrap at the top of the address space; byte offset bits ignored.
    do_reset("wrap");
    apply(mk(1, 32'hFFFF_FFF8, 0, 1, 0, 32'h0,         1, 32'h0000_0000), "wrap.miss");
    apply(mk(1, 32'hFFFF_FFF8, 0, 1, 1, ~32'hFFFF_FFF8, 1, 32'hFFFF_FFF8), "wrap.bypF8");
    apply(mk(0, 32'h0000_0000, 0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC), "wrap.fFC");
    apply(mk(1, 32'hFFFF_FFFC, 0, 1, 1, ~32'hFFFF_FFFC, 1, 32'h0000_0000), "wrap.hitFC");
    apply(mk(1, 32'h0000_0003, 0, 0, 1, ~32'h0000_0000, 1, 32'h0000_0004), "wrap.hit0");

    // Flush with three words buffered, then flush racing a push and a hit.
    do_reset("flush");
    apply(mk(0, 32'h00, 0, 1, 0, 32'h0,   1, 32'h00), "flush.f00");
    apply(mk(0, 32'h00, 0, 1, 0, 32'h0,   1, 32'h04), "flush.f04");
    apply(mk(0, 32'h00, 0, 1, 0, 32'h0,   1, 32'h08), "flush.f08");
    apply(mk(0, 32'h00, 1, 0, 0, 32'h0,   1, 32'h0C), "flush.pulse");
    apply(mk(1, 32'h00, 0, 0, 0, 32'h0,   1, 32'h0C), "flush.nostale");
    apply(mk(1, 32'h00, 0, 1, 0, 32'h0,   1, 32'h0C), "flush.drain");
    apply(mk(1, 32'h00, 0, 1, 1, ~32'h00, 1, 32'h00), "flush.refetch");
    apply(mk(0, 32'h00, 0, 1, 0, 32'h0,   1, 32'h04), "flush.f04b");
    apply(mk(0, 32'h00, 0, 1, 0, 32'h0,   1, 32'h08), "flush.f08b");
    apply(mk(1, 32'h04, 1, 1, 1, ~32'h04, 1, 32'h0C), "flush.hitpush");
    apply(mk(1, 32'h08, 0, 0, 0, 32'h0,   1, 32'h08), "flush.refetch08");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
